// File: rtl/t03_mmio_router.sv
// t03_mmio_router: CPU memory-mapped I/O router. One CPU load/store at a time
// is decoded to the Wishbone bus, a local output register bank, latched
// read-only input channels or a status register, and completes with one ack.
//
// Handshake: cpu_wen/cpu_ren is a request the CPU holds until cpu_ack; cpu_ack
// is a one-cycle pulse with cpu_dout/cpu_err valid in that cycle; the request
// must drop (HOLD) before the next one is accepted. On Wishbone, CYC_O/STB_O
// stay high until ACK_I is sampled high or the wait counter expires.
module t03_mmio_router #(
    parameter int         DATA_W   = 32,
    parameter int         NUM_REGS = 8,
    parameter int         NUM_IN   = 2,
    parameter logic [7:0] WB_TOP   = 8'h33,
    parameter int         TIMEOUT  = 255
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [31:0]                cpu_addr,
    input  logic [DATA_W-1:0]          cpu_din,
    input  logic                       cpu_wen,
    input  logic                       cpu_ren,
    output logic [DATA_W-1:0]          cpu_dout,
    output logic                       cpu_ack,
    output logic                       cpu_err,
    input  logic [NUM_IN*DATA_W-1:0]   in_data,
    input  logic [NUM_IN-1:0]          in_valid,
    output logic [NUM_REGS*DATA_W-1:0] reg_out,
    output logic [31:0]                ADR_O,
    output logic [31:0]                DAT_O,
    output logic [3:0]                 SEL_O,
    output logic                       WE_O,
    output logic                       STB_O,
    output logic                       CYC_O,
    input  logic [31:0]                DAT_I,
    input  logic                       ACK_I,
    output logic [2:0]                 state_dbg
);

    localparam int RIDX_W = $clog2(NUM_REGS);
    // Latched index field covers both the register index and the 5-bit channel index
    localparam int IDX_W  = (RIDX_W > 5) ? RIDX_W : 5;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [5:0]       NUM_IN_L = 6'(NUM_IN);

    typedef enum logic [2:0] {IDLE, LOCAL, WB, RESP, HOLD} state_t;

    state_t            state;
    logic [7:0]        top_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] din_q;
    logic              wr_q;
    logic              both_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic              err_bit;
    logic [DATA_W-1:0] regs_q   [NUM_REGS];
    logic [DATA_W-1:0] shadow_q [NUM_IN];
    logic [NUM_IN-1:0] fresh_q;

    logic              is_reg, is_ch, is_st, ch_ok, loc_err, chan_rd;
    logic [4:0]        ch_idx;
    logic [RIDX_W-1:0] ridx;
    logic [DATA_W-1:0] ch_word, status_word;

    assign SEL_O     = 4'hF;
    assign state_dbg = state;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[g*DATA_W +: DATA_W] = regs_q[g];
    end

    // Decode of the latched request, used by the LOCAL access
    always_comb begin
        is_reg      = (top_q == 8'hF0);
        is_ch       = (top_q == 8'hF1);
        is_st       = (top_q == 8'hF2);
        ch_idx      = idx_q[4:0];
        ridx        = idx_q[RIDX_W-1:0];
        ch_ok       = ({1'b0, ch_idx} < NUM_IN_L);
        loc_err     = both_q | (is_ch & (wr_q | ~ch_ok)) | (is_st & wr_q) |
                      ~(is_reg | is_ch | is_st);
        chan_rd     = (state == LOCAL) & is_ch & ~loc_err;
        ch_word     = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (ch_idx == 5'(i)) ch_word = shadow_q[i];
        end
        status_word = '0;
        status_word[NUM_IN-1:0] = fresh_q;
        status_word[31]         = err_bit;
    end

    // Request FSM with registered CPU and Wishbone outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            top_q    <= '0;
            idx_q    <= '0;
            din_q    <= '0;
            wr_q     <= 1'b0;
            both_q   <= 1'b0;
            wait_cnt <= '0;
            err_bit  <= 1'b0;
            cpu_dout <= '0;
            cpu_ack  <= 1'b0;
            cpu_err  <= 1'b0;
            ADR_O    <= '0;
            DAT_O    <= '0;
            WE_O     <= 1'b0;
            STB_O    <= 1'b0;
            CYC_O    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_wen || cpu_ren) begin
                        top_q  <= cpu_addr[31:24];
                        idx_q  <= cpu_addr[2 +: IDX_W];
                        din_q  <= cpu_din;
                        wr_q   <= cpu_wen;
                        both_q <= cpu_wen & cpu_ren;
                        // A simultaneous read+write never reaches the bus; LOCAL flags it
                        if (cpu_addr[31:24] == WB_TOP && !(cpu_wen && cpu_ren)) begin
                            state    <= WB;
                            CYC_O    <= 1'b1;
                            STB_O    <= 1'b1;
                            WE_O     <= cpu_wen;
                            ADR_O    <= {WB_TOP, cpu_addr[23:0]};
                            DAT_O    <= 32'(cpu_din);
                            wait_cnt <= '0;
                        end else begin
                            state <= LOCAL;
                        end
                    end
                end
                LOCAL: begin
                    state    <= RESP;
                    cpu_ack  <= 1'b1;
                    cpu_err  <= loc_err;
                    cpu_dout <= '0;
                    if (loc_err) begin
                        err_bit <= 1'b1;
                    end else if (is_reg) begin
                        if (wr_q) regs_q[ridx] <= din_q;
                        else      cpu_dout     <= regs_q[ridx];
                    end else if (is_ch) begin
                        cpu_dout <= ch_word;
                    end else if (is_st) begin
                        cpu_dout <= status_word;
                        err_bit  <= 1'b0;
                    end
                end
                WB: begin
                    // ACK_I is checked first so an ack on the last wait cycle wins
                    if (ACK_I) begin
                        state    <= RESP;
                        CYC_O    <= 1'b0;
                        STB_O    <= 1'b0;
                        WE_O     <= 1'b0;
                        cpu_ack  <= 1'b1;
                        cpu_err  <= 1'b0;
                        cpu_dout <= wr_q ? '0 : DATA_W'(DAT_I);
                    end else if (wait_cnt == CNT_LAST) begin
                        state    <= RESP;
                        CYC_O    <= 1'b0;
                        STB_O    <= 1'b0;
                        WE_O     <= 1'b0;
                        cpu_ack  <= 1'b1;
                        cpu_err  <= 1'b1;
                        cpu_dout <= '0;
                        err_bit  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state    <= HOLD;
                    cpu_ack  <= 1'b0;
                    cpu_err  <= 1'b0;
                    cpu_dout <= '0;
                end
                HOLD: begin
                    if (!cpu_wen && !cpu_ren) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Channel capture; a capture in the same cycle as a CPU read keeps fresh set
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fresh_q <= '0;
            for (int i = 0; i < NUM_IN; i++) shadow_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (chan_rd && ch_idx == 5'(i)) fresh_q[i] <= 1'b0;
                if (in_valid[i]) begin
                    shadow_q[i] <= in_data[i*DATA_W +: DATA_W];
                    fresh_q[i]  <= 1'b1;
                end
            end
        end
    end

endmodule
